// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared FSM encoding, latency defaults and a register-match helper
package pipe_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    MD_RUN = 1'b1
  } md_state_e;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 16;

  // Register 0 is hardwired to zero, so it never participates in a hazard.
  function automatic logic reg_match(input logic use_r, input logic [4:0] src,
                                     input logic [4:0] dst);
    return use_r && (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID/EX/MEM hazard inputs and pipeline control outputs
interface pipe_hazard_ctrl_if;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        use_rs_id;
  logic        use_rt_id;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [4:0]  mem_rd;
  logic        mem_regwrite;
  logic        md_start_id;
  logic        md_div_id;
  logic        hilo_read_id;
  logic        branch_taken_id;
  logic        pc_hold;
  logic        ifid_hold;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        md_busy;
  logic [31:0] stall_count;

  modport master (
    output rs_id, rt_id, use_rs_id, use_rt_id, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, md_start_id, md_div_id, hilo_read_id, branch_taken_id,
    input  pc_hold, ifid_hold, idex_bubble, ifid_flush, md_busy, stall_count
  );

  modport slave (
    input  rs_id, rt_id, use_rs_id, use_rt_id, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, md_start_id, md_div_id, hilo_read_id, branch_taken_id,
    output pc_hold, ifid_hold, idex_bubble, ifid_flush, md_busy, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl_md_sched.sv
// rtl/pipe_hazard_ctrl_md_sched.sv - multiply/divide occupancy FSM with latency down-counter
module md_sched
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_i,
  input  logic md_div_i,
  input  logic stall_i,
  output logic md_busy_o
);

  localparam logic [4:0] MUL_LOAD = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_LAT - 1);

  md_state_e  state_q, state_d;
  logic [4:0] md_cnt_q, md_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      md_cnt_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // A start held under a stall is not taken; it issues once the stall clears.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      IDLE: begin
        if (md_start_i && !stall_i) begin
          state_d  = MD_RUN;
          md_cnt_d = md_div_i ? DIV_LOAD : MUL_LOAD;
        end
      end
      MD_RUN: begin
        if (md_cnt_q == 5'd0) begin
          state_d = IDLE;
        end else begin
          md_cnt_d = md_cnt_q - 5'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        md_cnt_d = 5'd0;
      end
    endcase
  end

  assign md_busy_o = (state_q == MD_RUN);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush control; PIPE_HAZARD_FORWARDING_EN drops RAW stalls
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  logic        load_use;
  logic        md_hazard;
  logic        raw_hazard;
  logic        stall;
  logic        md_busy;
  logic [31:0] stall_count_q, stall_count_d;

  assign load_use = hz.ex_memread &&
                    (reg_match(hz.use_rs_id, hz.rs_id, hz.ex_rd) ||
                     reg_match(hz.use_rt_id, hz.rt_id, hz.ex_rd));

  assign md_hazard = md_busy && (hz.md_start_id || hz.hilo_read_id);

`ifdef PIPE_HAZARD_FORWARDING_EN
  assign raw_hazard = 1'b0;
`else
  // Without bypass paths every in-flight writer of a source register blocks ID.
  assign raw_hazard =
      (hz.ex_regwrite  && (reg_match(hz.use_rs_id, hz.rs_id, hz.ex_rd) ||
                           reg_match(hz.use_rt_id, hz.rt_id, hz.ex_rd))) ||
      (hz.mem_regwrite && (reg_match(hz.use_rs_id, hz.rs_id, hz.mem_rd) ||
                           reg_match(hz.use_rt_id, hz.rt_id, hz.mem_rd)));
`endif

  assign stall = load_use || md_hazard || raw_hazard;

  assign hz.pc_hold     = stall;
  assign hz.ifid_hold   = stall;
  assign hz.idex_bubble = stall;
  assign hz.ifid_flush  = hz.branch_taken_id && !stall;
  assign hz.md_busy     = md_busy;
  assign hz.stall_count = stall_count_q;

  md_sched #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_sched (
    .clk        (clk),
    .reset      (reset),
    .md_start_i (hz.md_start_id),
    .md_div_i   (hz.md_div_id),
    .stall_i    (stall),
    .md_busy_o  (md_busy)
  );

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;

  localparam int MUL_L = 4;
  localparam int DIV_L = 16;

  logic clk;
  logic reset;
  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_total = 0;
  int     n_pass  = 0;
  int     m_left  = 0;
  longint m_cnt   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic writes(input logic we, input logic [4:0] dst,
                                  input logic u, input logic [4:0] src);
    return we && u && (src != 5'd0) && (src == dst);
  endfunction

  task automatic model_step();
    logic lu, mh, raw, st, busy;
    logic [4:0] src [2];
    logic       use_s [2];
    if (reset) begin
      m_left = 0;
      m_cnt  = 0;
    end
    src[0] = hz.rs_id; src[1] = hz.rt_id;
    use_s[0] = hz.use_rs_id; use_s[1] = hz.use_rt_id;
    lu = 1'b0; raw = 1'b0;
    for (int k = 0; k < 2; k++) begin
      lu  = lu  | writes(hz.ex_memread, hz.ex_rd, use_s[k], src[k]);
      raw = raw | writes(hz.ex_regwrite, hz.ex_rd, use_s[k], src[k])
                | writes(hz.mem_regwrite, hz.mem_rd, use_s[k], src[k]);
    end
`ifdef PIPE_HAZARD_FORWARDING_EN
    raw = 1'b0;
`endif
    busy = (m_left > 0);
    mh   = busy && (hz.md_start_id || hz.hilo_read_id);
    st   = lu || mh || raw;
    chk("pc_hold", 32'(hz.pc_hold), 32'(st));
    chk("ifid_hold", 32'(hz.ifid_hold), 32'(st));
    chk("idex_bubble", 32'(hz.idex_bubble), 32'(st));
    chk("ifid_flush", 32'(hz.ifid_flush), 32'(hz.branch_taken_id && !st));
    chk("md_busy", 32'(hz.md_busy), 32'(busy));
    chk("stall_count", hz.stall_count, m_cnt[31:0]);
    if (!reset) begin
      if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_left > 0) m_left--;
      else if (hz.md_start_id && !st) m_left = hz.md_div_id ? DIV_L : MUL_L;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_step();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hz.rs_id = 5'd0; hz.rt_id = 5'd0; hz.use_rs_id = 1'b0; hz.use_rt_id = 1'b0;
    hz.ex_rd = 5'd0; hz.ex_regwrite = 1'b0; hz.ex_memread = 1'b0;
    hz.mem_rd = 5'd0; hz.mem_regwrite = 1'b0;
    hz.md_start_id = 1'b0; hz.md_div_id = 1'b0; hz.hilo_read_id = 1'b0;
    hz.branch_taken_id = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    reset = 1'b1;
    clear_in();
    at_neg(); next();
    at_neg();
    chk("rst_md_busy", 32'(hz.md_busy), 32'd0);
    chk("rst_stall_count", hz.stall_count, 32'd0);
    next();
    reset = 1'b0;

    // Load-use on rs = 8: one stall cycle, counter then reads 1.
    hz.ex_memread = 1'b1; hz.ex_regwrite = 1'b1; hz.ex_rd = 5'd8;
    hz.use_rs_id = 1'b1; hz.rs_id = 5'd8;
    at_neg();
    chk("lu_stall", 32'(hz.pc_hold), 32'd1);
    next();
    clear_in();
    at_neg();
    chk("lu_stall_gone", 32'(hz.pc_hold), 32'd0);
    chk("lu_count", hz.stall_count, 32'd1);
    next();

    // Register zero never stalls.
    hz.ex_memread = 1'b1; hz.ex_regwrite = 1'b1; hz.ex_rd = 5'd0;
    hz.use_rs_id = 1'b1; hz.rs_id = 5'd0; hz.use_rt_id = 1'b1; hz.rt_id = 5'd0;
    at_neg();
    chk("r0_no_stall", 32'(hz.pc_hold), 32'd0);
    next();
    clear_in();

    // Divide then HI/LO read: busy for DIV_L cycles, stalled until it drops.
    hz.md_start_id = 1'b1; hz.md_div_id = 1'b1;
    at_neg();
    chk("div_issue_no_stall", 32'(hz.pc_hold), 32'd0);
    next();
    clear_in();
    hz.hilo_read_id = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      at_neg();
      chk("div_flush", 32'(hz.ifid_flush), 32'd0);
      if (!hz.md_busy) break;
      busy_cycles++;
      chk("div_stall", 32'(hz.pc_hold), 32'd1);
      next();
    end
    chk("div_busy_cycles", 32'(busy_cycles), 32'd16);
    chk("div_stall_released", 32'(hz.pc_hold), 32'd0);
    next();
    clear_in();

    // Branch under load-use stall: flush deferred to the unstalled cycle.
    hz.ex_memread = 1'b1; hz.ex_rd = 5'd9; hz.use_rt_id = 1'b1; hz.rt_id = 5'd9;
    hz.branch_taken_id = 1'b1;
    at_neg();
    chk("br_stalled_flush", 32'(hz.ifid_flush), 32'd0);
    next();
    hz.ex_memread = 1'b0; hz.ex_rd = 5'd0;
    at_neg();
    chk("br_flush", 32'(hz.ifid_flush), 32'd1);
    next();
    clear_in();

    // MEM-stage writer of rt = 5 stalls only without forwarding.
    hz.mem_regwrite = 1'b1; hz.mem_rd = 5'd5; hz.use_rt_id = 1'b1; hz.rt_id = 5'd5;
    at_neg();
`ifdef PIPE_HAZARD_FORWARDING_EN
    chk("mem_raw_stall", 32'(hz.pc_hold), 32'd0);
`else
    chk("mem_raw_stall", 32'(hz.pc_hold), 32'd1);
`endif
    next();
    clear_in();

    // Reset mid-divide with md_cnt = 7 clears busy and counter before any edge.
    hz.md_start_id = 1'b1; hz.md_div_id = 1'b1;
    at_neg(); next();
    clear_in();
    for (int i = 0; i < 8; i++) begin
      at_neg(); next();
    end
    @(negedge clk);
    chk("pre_rst_busy", 32'(hz.md_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(hz.md_busy), 32'd0);
    chk("mid_rst_count", hz.stall_count, 32'd0);
    model_step();
    next();
    reset = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      hz.rs_id = 5'($urandom_range(0, 3)); hz.rt_id = 5'($urandom_range(0, 3));
      hz.use_rs_id = 1'($urandom_range(0, 1)); hz.use_rt_id = 1'($urandom_range(0, 1));
      hz.ex_rd = 5'($urandom_range(0, 3)); hz.mem_rd = 5'($urandom_range(0, 3));
      hz.ex_regwrite = ($urandom_range(0, 2) == 0);
      hz.ex_memread = ($urandom_range(0, 3) == 0);
      hz.mem_regwrite = ($urandom_range(0, 2) == 0);
      hz.md_start_id = ($urandom_range(0, 7) == 0);
      hz.md_div_id = 1'($urandom_range(0, 1));
      hz.hilo_read_id = ($urandom_range(0, 5) == 0);
      hz.branch_taken_id = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 199) == 0);
      at_neg(); next();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
